alu_issue: RTL and testbench

- Initiator side of the ALU device interface.
- Accepts add/subtract requests from the control unit over a valid/ready handshake and drives op/a/b into the ALU for exactly one cycle.
- Captures the ALU result and flags, then returns the result on a response handshake.
- Holds the architectural status register (ZF, CF, OF, SF) and evaluates branch conditions from it for the jump logic.

---
 rtl/alu_issue.sv | 168 ++++++++++++++++
 tb/tb_alu_issue.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// alu_issue: initiator side of the ALU device interface. Issues add/sub
// requests to the ALU for one cycle, returns the result and owns the
// architectural status flags plus the branch-condition evaluator.
// Ports: clk, rst_n (async active-low); req_* request handshake;
//   rsp_* response handshake; alu_op/alu_a/alu_b to the ALU, alu_s and
//   alu_cf/of/zf/sf back; stat_zf/cf/of/sf status; cond_sel/cond_true.
// Optional: define ALU_ISSUE_CMP_EN to let req_cmp run flags-only ops.

package pkg_reg;
    localparam int REG_WIDTH = 64;
endpackage

package pkg_alu;
    typedef enum logic [1:0] {
        ALU_NOP = 2'd0,
        ALU_ADD = 2'd1,
        ALU_SUB = 2'd2
    } alu_op_t;
endpackage

module alu_issue
    import pkg_alu::*;
#(
    parameter int WIDTH        = pkg_reg::REG_WIDTH,
    parameter int DST_WIDTH    = 4,
    parameter int ALU_OP_WIDTH = $bits(alu_op_t)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_sub,
    input  logic                    req_cmp,
    input  logic [WIDTH-1:0]        req_a,
    input  logic [WIDTH-1:0]        req_b,
    input  logic [DST_WIDTH-1:0]    req_dst,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_data,
    output logic [DST_WIDTH-1:0]    rsp_dst,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic [WIDTH-1:0]        alu_a,
    output logic [WIDTH-1:0]        alu_b,
    input  logic [WIDTH-1:0]        alu_s,
    input  logic                    alu_cf,
    input  logic                    alu_of,
    input  logic                    alu_zf,
    input  logic                    alu_sf,
    output logic                    stat_zf,
    output logic                    stat_cf,
    output logic                    stat_of,
    output logic                    stat_sf,
    input  logic [2:0]              cond_sel,
    output logic                    cond_true
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [WIDTH-1:0]       a_q;
    logic [WIDTH-1:0]       b_q;
    logic [DST_WIDTH-1:0]   dst_q;
    logic                   sub_q;
    logic                   cmp_q;
    logic                   cmp_in;

`ifdef ALU_ISSUE_CMP_EN
    assign cmp_in = req_cmp;
`else
    // Compare requests disabled: every request is a normal one.
    assign cmp_in = req_cmp & 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_op    = ALU_OP_WIDTH'(ALU_NOP);
        alu_a     = '0;
        alu_b     = '0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                alu_op    = sub_q ? ALU_OP_WIDTH'(ALU_SUB)
                                  : ALU_OP_WIDTH'(ALU_ADD);
                alu_a     = a_q;
                alu_b     = b_q;
                state_nxt = cmp_q ? IDLE : RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            dst_q    <= '0;
            sub_q    <= 1'b0;
            cmp_q    <= 1'b0;
            rsp_data <= '0;
            rsp_dst  <= '0;
            stat_zf  <= 1'b0;
            stat_cf  <= 1'b0;
            stat_of  <= 1'b0;
            stat_sf  <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                a_q   <= req_a;
                b_q   <= req_b;
                dst_q <= req_dst;
                sub_q <= req_sub;
                cmp_q <= cmp_in;
            end
            if (state == EXEC) begin
                stat_zf <= alu_zf;
                stat_cf <= alu_cf;
                stat_of <= alu_of;
                stat_sf <= alu_sf;
                // A compare leaves the previous result visible.
                if (!cmp_q) begin
                    rsp_data <= alu_s;
                    rsp_dst  <= dst_q;
                end
            end
        end
    end

    always_comb begin
        cond_true = 1'b1;
        unique case (cond_sel)
            3'd0: cond_true = 1'b1;
            3'd1: cond_true = stat_zf;
            3'd2: cond_true = ~stat_zf;
            3'd3: cond_true = stat_cf;
            3'd4: cond_true = ~stat_cf;
            3'd5: cond_true = stat_sf ^ stat_of;
            3'd6: cond_true = ~(stat_sf ^ stat_of);
            3'd7: cond_true = ~stat_cf & ~stat_zf;
            default: cond_true = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed bench for alu_issue with a behavioural ALU.
// Checks latency, results, flags, conditions, backpressure and reset.

module tb_alu_issue;
    import pkg_alu::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_sub;
    logic        req_cmp;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_dst;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic [3:0]  rsp_dst;
    logic [1:0]  alu_op;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [63:0] alu_s;
    logic        alu_cf;
    logic        alu_of;
    logic        alu_zf;
    logic        alu_sf;
    logic        stat_zf;
    logic        stat_cf;
    logic        stat_of;
    logic        stat_sf;
    logic [2:0]  cond_sel;
    logic        cond_true;

    int n_chk;
    int n_pass;

    alu_issue dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_sub(req_sub), .req_cmp(req_cmp),
        .req_a(req_a), .req_b(req_b), .req_dst(req_dst),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_dst(rsp_dst),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_s(alu_s), .alu_cf(alu_cf), .alu_of(alu_of),
        .alu_zf(alu_zf), .alu_sf(alu_sf),
        .stat_zf(stat_zf), .stat_cf(stat_cf),
        .stat_of(stat_of), .stat_sf(stat_sf),
        .cond_sel(cond_sel), .cond_true(cond_true)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU: dst = b op a; when idle it shows a junk accumulator and flags.
    always_comb begin
        alu_s  = '0;
        alu_cf = 1'b0;
        alu_of = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                {alu_cf, alu_s} = {1'b0, alu_b} + {1'b0, alu_a};
                alu_of = (alu_a[63] == alu_b[63]) && (alu_s[63] != alu_b[63]);
            end
            ALU_SUB: begin
                {alu_cf, alu_s} = {1'b0, alu_b} - {1'b0, alu_a};
                alu_of = (alu_a[63] != alu_b[63]) && (alu_s[63] != alu_b[63]);
            end
            default: begin
                alu_s  = 64'hA5A5_A5A5_A5A5_A5A5;
                alu_cf = 1'b1;
                alu_of = 1'b1;
            end
        endcase
        alu_zf = (alu_s == '0) || (alu_op == ALU_NOP);
        alu_sf = alu_s[63];
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    function automatic logic [3:0] flags();
        return {stat_zf, stat_cf, stat_of, stat_sf};
    endfunction

    task automatic chk_cond(input logic [2:0] sel, input logic exp);
        cond_sel = sel;
        #1;
        check($sformatf("cond%0d", sel), 64'(cond_true), 64'(exp));
    endtask

    task automatic wait_rsp(input int exp_lat);
        int k;
        k = 0;
        while (!rsp_valid && k < 8) begin
            @(negedge clk);
            k++;
        end
        check("rsp_lat", 64'(k), 64'(exp_lat));
    endtask

    // Called at a negedge; returns at the negedge where rsp_valid is high.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                          input logic sub, input logic cmp,
                          input logic [3:0] dst, input logic [63:0] ed,
                          input logic [3:0] ef);
        req_a = a; req_b = b; req_sub = sub;
        req_cmp = cmp; req_dst = dst; req_valid = 1'b1;
        check("idle_rdy", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("exec_op", 64'(alu_op),
              64'(sub ? ALU_SUB : ALU_ADD));
        check("exec_rdy", 64'(req_ready), 64'd0);
        wait_rsp(1);
        check("rsp_data", rsp_data, ed);
        check("rsp_dst", 64'(rsp_dst), 64'(dst));
        check("flags", 64'(flags()), 64'(ef));
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rel_valid", 64'(rsp_valid), 64'd0);
        check("rel_rdy", 64'(req_ready), 64'd1);
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_sub = 1'b0;
        req_cmp = 1'b0; req_a = '0; req_b = '0; req_dst = '0;
        rsp_ready = 1'b0; cond_sel = 3'd0;
        repeat (2) @(negedge clk);
        check("rst_rdy", 64'(req_ready), 64'd1);
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_data", rsp_data, 64'd0);
        check("rst_flags", 64'(flags()), 64'd0);
        check("rst_op", 64'(alu_op), 64'(ALU_NOP));
        check("rst_ab", alu_a | alu_b, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(64'd3, 64'd5, 1'b0, 1'b0, 4'd2, 64'd8, 4'b0000);
        chk_cond(3'd7, 1'b1);
        chk_cond(3'd0, 1'b1);
        release_rsp();

        run_op(64'd5, 64'd5, 1'b1, 1'b0, 4'd1, 64'd0, 4'b1000);
        chk_cond(3'd1, 1'b1);
        chk_cond(3'd2, 1'b0);
        release_rsp();

        run_op(64'd1, 64'd0, 1'b1, 1'b0, 4'd5,
               64'hFFFF_FFFF_FFFF_FFFF, 4'b0101);
        chk_cond(3'd3, 1'b1);
        chk_cond(3'd5, 1'b1);
        chk_cond(3'd4, 1'b0);
        release_rsp();

        run_op(64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 4'd6,
               64'h8000_0000_0000_0000, 4'b0011);
        chk_cond(3'd5, 1'b0);
        chk_cond(3'd6, 1'b1);
        release_rsp();

        // Backpressure with a second request pending.
        run_op(64'd20, 64'd10, 1'b0, 1'b0, 4'd3, 64'd30, 4'b0000);
        req_a = 64'd2; req_b = 64'd1; req_sub = 1'b1;
        req_dst = 4'd4; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(rsp_valid), 64'd1);
            check("bp_data", rsp_data, 64'd30);
            check("bp_dst", 64'(rsp_dst), 64'd3);
            check("bp_rdy", 64'(req_ready), 64'd0);
            check("bp_op", 64'(alu_op), 64'(ALU_NOP));
            check("bp_flags", 64'(flags()), 64'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_hs_valid", 64'(rsp_valid), 64'd0);
        check("bp_hs_rdy", 64'(req_ready), 64'd1);
        check("bp_hs_op", 64'(alu_op), 64'(ALU_NOP));
        @(negedge clk);
        req_valid = 1'b0;
        check("bp2_op", 64'(alu_op), 64'(ALU_SUB));
        check("bp2_a", alu_a, 64'd2);
        check("bp2_b", alu_b, 64'd1);
        wait_rsp(1);
        check("bp2_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
        check("bp2_dst", 64'(rsp_dst), 64'd4);
        check("bp2_flags", 64'(flags()), 64'b0101);
        release_rsp();

        // Reset while the ALU is active.
        req_a = 64'd9; req_b = 64'd4; req_sub = 1'b0;
        req_dst = 4'd7; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("pre_rst_op", 64'(alu_op), 64'(ALU_ADD));
        #2 rst_n = 1'b0;
        #1;
        check("mrst_rdy", 64'(req_ready), 64'd1);
        check("mrst_valid", 64'(rsp_valid), 64'd0);
        check("mrst_flags", 64'(flags()), 64'd0);
        check("mrst_op", 64'(alu_op), 64'(ALU_NOP));
        check("mrst_data", rsp_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef ALU_ISSUE_CMP_EN
        req_a = 64'd5; req_b = 64'd5; req_sub = 1'b1;
        req_cmp = 1'b1; req_dst = 4'd9; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("cmp_op", 64'(alu_op), 64'(ALU_SUB));
        @(negedge clk);
        check("cmp_valid", 64'(rsp_valid), 64'd0);
        check("cmp_rdy", 64'(req_ready), 64'd1);
        check("cmp_flags", 64'(flags()), 64'b1000);
        check("cmp_data", rsp_data, 64'd0);
        check("cmp_dst", 64'(rsp_dst), 64'd0);
        req_cmp = 1'b0;
`else
        run_op(64'd5, 64'd5, 1'b1, 1'b1, 4'd9, 64'd0, 4'b1000);
        req_cmp = 1'b0;
        release_rsp();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want done");
        $fatal(1);
    end

endmodule
